// File: rtl/arb_mux_n.sv
// arb_mux_n: N-channel valid/ready arbiter feeding a single registered output.
// One channel is granted per cycle (round-robin or fixed priority) and its word
// is captured into the output register, which has its own valid/ready handshake.
//
// Handshake semantics (both sides): a word moves on a rising edge when valid and
// ready are both high in the cycle before that edge. A source holds valid and its
// word stable until it is taken; ready may depend combinationally on valid.
module arb_mux_n #(
   parameter int NB_DATA = 32,
   parameter int N_CH    = 4,
   parameter int NB_SEL  = 2,
   parameter int MODE    = 0
) (
   input  logic                    i_clk,
   input  logic                    i_rst_n,
   input  logic [N_CH*NB_DATA-1:0] i_data,
   input  logic [N_CH-1:0]         i_valid,
   output logic [N_CH-1:0]         o_ready,
   output logic [NB_DATA-1:0]      o_data,
   output logic                    o_valid,
   output logic [NB_SEL-1:0]       o_sel,
   input  logic                    i_ready
);

   // Index of the most recent transfer; the round-robin scan starts just past it.
   logic [NB_SEL-1:0] last_gnt;
   logic [NB_SEL-1:0] gnt_idx;
   logic              gnt_any;
   logic              load_en;

   // Output register is empty or being drained this cycle, so it can take a word.
   assign load_en = !o_valid || i_ready;

   // Pick the winning channel from the current valids.
   always_comb begin
      int idx;
      gnt_any = 1'b0;
      gnt_idx = '0;
      idx     = 0;
      if (MODE == 1) begin
         // Walk downwards so the lowest valid index is the last one written.
         for (int k = N_CH - 1; k >= 0; k--) begin
            if (i_valid[k]) begin
               gnt_any = 1'b1;
               gnt_idx = NB_SEL'(k);
            end
         end
      end else begin
         // Scan last_gnt+1, last_gnt+2, ... wrapping; first valid channel wins.
         for (int off = 1; off <= N_CH; off++) begin
            idx = (int'(last_gnt) + off) % N_CH;
            if (!gnt_any && i_valid[idx]) begin
               gnt_any = 1'b1;
               gnt_idx = NB_SEL'(idx);
            end
         end
      end
   end

   // Ready goes only to the granted channel, and only when the register can load.
   always_comb begin
      o_ready = '0;
      if (load_en && gnt_any) begin
         o_ready[gnt_idx] = 1'b1;
      end
   end

   // Output register and round-robin pointer; the pointer moves only on transfers.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_valid  <= 1'b0;
         o_data   <= '0;
         o_sel    <= '0;
         last_gnt <= NB_SEL'(N_CH - 1);
      end else if (load_en) begin
         if (gnt_any) begin
            o_valid  <= 1'b1;
            o_data   <= i_data[int'(gnt_idx)*NB_DATA +: NB_DATA];
            o_sel    <= gnt_idx;
            last_gnt <= gnt_idx;
         end else begin
            o_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_arb_mux_n.sv
// Bench for arb_mux_n: one round-robin and one fixed-priority instance share the
// inputs; the bench looks at whichever one the current phase is exercising.
module tb_arb_mux_n;
   localparam int W = 32;
   localparam int N = 4;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [N*W-1:0] i_data = '0;
   logic [N-1:0]   i_valid = '0;
   logic           i_ready = 1'b0;

   logic [N-1:0] rdy_rr, rdy_fp;
   logic [W-1:0] dat_rr, dat_fp;
   logic         val_rr, val_fp;
   logic [1:0]   sel_rr, sel_fp;

   arb_mux_n #(.NB_DATA(W), .N_CH(N), .NB_SEL(2), .MODE(0)) u_rr (
      .i_clk(clk), .i_rst_n(rst_n), .i_data(i_data), .i_valid(i_valid),
      .o_ready(rdy_rr), .o_data(dat_rr), .o_valid(val_rr), .o_sel(sel_rr),
      .i_ready(i_ready));

   arb_mux_n #(.NB_DATA(W), .N_CH(N), .NB_SEL(2), .MODE(1)) u_fp (
      .i_clk(clk), .i_rst_n(rst_n), .i_data(i_data), .i_valid(i_valid),
      .o_ready(rdy_fp), .o_data(dat_fp), .o_valid(val_fp), .o_sel(sel_fp),
      .i_ready(i_ready));

   bit mode = 1'b0;
   wire [N-1:0] o_ready = mode ? rdy_fp : rdy_rr;
   wire [W-1:0] o_data  = mode ? dat_fp : dat_rr;
   wire         o_valid = mode ? val_fp : val_rr;
   wire [1:0]   o_sel   = mode ? sel_fp : sel_rr;

   // ---------------- scoreboard / model state ----------------
   logic [W+1:0] exp_q[$];
   int           checks = 0;
   int           errors = 0;
   logic [W-1:0] words[N];
   bit           m_valid = 1'b0;
   int           m_lg = N - 1;
   int           last_xfer = -1;

   task automatic chk(input string name, input logic [W+1:0] act, input logic [W+1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference arbitration straight from the rules: fixed mode takes the lowest
   // valid index; round-robin takes the first valid one after the last winner.
   function automatic int model_grant(input logic [N-1:0] v, input int lg, input bit m);
      if (v == '0) return -1;
      if (m) begin
         for (int i = 0; i < N; i++) if (v[i]) return i;
      end
      for (int off = 1; off <= N; off++) begin
         if (v[(lg + off) % N]) return (lg + off) % N;
      end
      return -1;
   endfunction

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      if (rst_n) begin
         chk("occupancy", {33'b0, o_valid}, {33'b0, (exp_q.size() != 0)});
         if (o_valid && exp_q.size() != 0) begin
            chk("out_word", {o_sel, o_data}, exp_q[0]);
            if (i_ready) void'(exp_q.pop_front());
         end
      end
   end

   // ---------------- driver tasks ----------------
   // Called just after a rising edge; applies inputs, checks ready at the falling
   // edge, records the expected word, and returns just after the next rising edge.
   // exp_g: >=0 directed grant, -2 directed "no ready", -1 none.
   task automatic cycle(input logic [N-1:0] v, input logic rdy, input int exp_g);
      int g;
      bit load_en;
      logic [N-1:0] exp_r;
      for (int k = 0; k < N; k++) i_data[k*W +: W] = words[k];
      i_valid = v;
      i_ready = rdy;
      @(negedge clk);
      #1;
      load_en = !m_valid || rdy;
      g = model_grant(v, m_lg, mode);
      exp_r = (load_en && g >= 0) ? N'(1 << g) : '0;
      chk("o_ready", {30'b0, o_ready}, {30'b0, exp_r});
      if (exp_g >= 0) chk("dir_grant", {30'b0, o_ready}, {30'b0, N'(1 << exp_g)});
      if (exp_g == -2) chk("dir_no_ready", {30'b0, o_ready}, '0);
      if (exp_r != '0) begin
         exp_q.push_back({2'(g), words[g]});
         m_lg = g;
         m_valid = 1'b1;
         last_xfer = g;
      end else begin
         last_xfer = -1;
         if (load_en) m_valid = 1'b0;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input bit new_mode);
      rst_n = 1'b0;
      i_valid = '0;
      i_ready = 1'b0;
      exp_q.delete();
      m_valid = 1'b0;
      m_lg = N - 1;
      last_xfer = -1;
      mode = new_mode;
      @(posedge clk);
      @(posedge clk);
      #1;
      chk("rst_valid", {33'b0, o_valid}, '0);
      chk("rst_data", {2'b0, o_data}, '0);
      chk("rst_sel", {32'b0, o_sel}, '0);
      chk("rst_ready", {30'b0, o_ready}, '0);
      rst_n = 1'b1;
   endtask

   task automatic random_run(input int n);
      logic [N-1:0] cur_v = '0;
      for (int i = 0; i < n; i++) begin
         for (int k = 0; k < N; k++) begin
            if (last_xfer == k) cur_v[k] = 1'b0;
            if (!cur_v[k] && $urandom_range(0, 1) == 1) begin
               cur_v[k] = 1'b1;
               words[k] = $urandom;
            end
         end
         cycle(cur_v, $urandom_range(0, 3) != 0, -1);
      end
      for (int i = 0; i < 3; i++) cycle('0, 1'b1, -1);
      chk("drained", {2'b0, 32'(exp_q.size())}, '0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      for (int k = 0; k < N; k++) words[k] = 32'hA000_0000 | k;

      // Single channel, one-cycle latency.
      do_reset(1'b0);
      words[2] = 32'hCAFE_0002;
      cycle(4'b0100, 1'b1, 2);
      chk("t1_valid", {33'b0, o_valid}, {33'b0, 1'b1});
      chk("t1_data", {2'b0, o_data}, {2'b0, 32'hCAFE_0002});
      chk("t1_sel", {32'b0, o_sel}, {32'b0, 2'd2});
      cycle('0, 1'b1, -2);

      // Round-robin fairness at full rate.
      do_reset(1'b0);
      for (int i = 0; i < 8; i++) cycle(4'b1111, 1'b1, i % N);
      cycle('0, 1'b1, -2);

      // Backpressure holds everything, then the pointer resumes after ch1.
      do_reset(1'b0);
      words[1] = 32'h1111_0001;
      cycle(4'b0010, 1'b1, 1);
      for (int i = 0; i < 5; i++) cycle(4'b1111, 1'b0, -2);
      chk("t3_sel_hold", {32'b0, o_sel}, {32'b0, 2'd1});
      chk("t3_data_hold", {2'b0, o_data}, {2'b0, 32'h1111_0001});
      cycle(4'b1111, 1'b1, 2);
      cycle('0, 1'b1, -1);
      cycle('0, 1'b1, -1);

      // Wrap and skip from last_gnt=3 with only ch1/ch3 active.
      do_reset(1'b0);
      cycle(4'b1010, 1'b1, 1);
      cycle(4'b1010, 1'b1, 3);
      cycle(4'b1010, 1'b1, 1);
      cycle('0, 1'b1, -1);

      // Fixed priority.
      do_reset(1'b1);
      for (int i = 0; i < 3; i++) cycle(4'b1111, 1'b1, 0);
      cycle(4'b1110, 1'b1, 1);
      cycle('0, 1'b1, -1);

      // Async reset mid-stream, then ch0 wins first.
      do_reset(1'b0);
      words[3] = 32'hDEAD_0003;
      cycle(4'b1000, 1'b0, 3);
      #2;
      rst_n = 1'b0;
      #1;
      chk("t6_valid", {33'b0, o_valid}, '0);
      chk("t6_data", {2'b0, o_data}, '0);
      chk("t6_sel", {32'b0, o_sel}, '0);
      exp_q.delete();
      m_valid = 1'b0;
      m_lg = N - 1;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      cycle(4'b1111, 1'b1, 0);
      cycle('0, 1'b1, -1);

      // Randomised traffic in both modes.
      do_reset(1'b0);
      random_run(400);
      do_reset(1'b1);
      random_run(400);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
